// File: rtl/i2c_target.sv
// I2C target with an 8-bit register window.
// Write protocol: [addr+W] [reg pointer] [data]* ; read protocol: [addr+R] [data]*.
// The register pointer survives repeated START and STOP, so "write pointer,
// repeated START, read" addresses the register just written as the pointer.
// Handshake: the register file sees reg_wr_en as a one-cycle strobe
// qualifying reg_addr/reg_wr_data. reg_rd_data is combinational from reg_addr
// and is sampled only on the SCL fall that loads a read byte.
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h1D,
    parameter int         NUM_REGS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_data,
    input  logic [7:0] reg_rd_data,
    output logic       busy,
    output logic [3:0] fsm_state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ACK_ADDR  = 4'd2,
        S_REG       = 4'd3,
        S_ACK_REG   = 4'd4,
        S_WDATA     = 4'd5,
        S_ACK_WDATA = 4'd6,
        S_RDATA     = 4'd7,
        S_RACK      = 4'd8
    } state_t;

    localparam logic [7:0] LAST_REG = 8'(NUM_REGS - 1);

    state_t     state, state_nx;
    logic       scl_s1, scl_s2, scl_d;
    logic       sda_s1, sda_s2, sda_d;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] tx_byte;
    logic [2:0] tx_cnt;
    logic       acked;
    logic       addr_match;
    logic [7:0] reg_mod;

    function automatic logic [7:0] addr_inc(input logic [7:0] a);
        return (a == LAST_REG) ? 8'd0 : a + 8'd1;
    endfunction

    // Two-flop synchronizers plus one delayed copy for edge detection; idle bus is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
        end else begin
            scl_s1 <= scl_i; scl_s2 <= scl_s1; scl_d <= scl_s2;
            sda_s1 <= sda_i; sda_s2 <= sda_s1; sda_d <= sda_s2;
        end
    end

    assign scl_rise   = scl_s2 & ~scl_d;
    assign scl_fall   = ~scl_s2 & scl_d;
    assign start_det  = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det   = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign addr_match = (shreg[7:1] == DEV_ADDR);
    assign reg_mod    = 8'(32'(shreg) % NUM_REGS);
    assign fsm_state  = state;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state logic; STOP and START override every state.
    always_comb begin
        state_nx = state;
        if (stop_det) begin
            state_nx = S_IDLE;
        end else if (start_det) begin
            state_nx = S_ADDR;
        end else begin
            case (state)
                S_ADDR:      if (scl_fall && bit_cnt == 4'd8) state_nx = addr_match ? S_ACK_ADDR : S_IDLE;
                S_ACK_ADDR:  if (scl_fall) state_nx = shreg[0] ? S_RDATA : S_REG;
                S_REG:       if (scl_fall && bit_cnt == 4'd8) state_nx = S_ACK_REG;
                S_ACK_REG:   if (scl_fall) state_nx = S_WDATA;
                S_WDATA:     if (scl_fall && bit_cnt == 4'd8) state_nx = S_ACK_WDATA;
                S_ACK_WDATA: if (scl_fall) state_nx = S_WDATA;
                S_RDATA:     if (scl_fall && tx_cnt == 3'd7) state_nx = S_RACK;
                S_RACK: begin
                    if (scl_rise && sda_s2)     state_nx = S_IDLE;
                    else if (scl_fall && acked) state_nx = S_RDATA;
                end
                default:     state_nx = S_IDLE;
            endcase
        end
    end

    // SDA drive decoded from registered state, so it moves only after an SCL fall or START/STOP.
    always_comb begin
        sda_oe = 1'b0;
        case (state)
            S_ACK_ADDR, S_ACK_REG, S_ACK_WDATA: sda_oe = 1'b1;
            S_RDATA:                            sda_oe = ~tx_byte[7];
            default:                            sda_oe = 1'b0;
        endcase
    end

    // Datapath: shift register, bit counters, register pointer, write strobe and busy flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt     <= 4'd0;
            shreg       <= 8'd0;
            tx_byte     <= 8'd0;
            tx_cnt      <= 3'd0;
            acked       <= 1'b0;
            busy        <= 1'b0;
            reg_addr    <= 8'd0;
            reg_wr_en   <= 1'b0;
            reg_wr_data <= 8'd0;
        end else begin
            reg_wr_en <= 1'b0;
            if (stop_det) begin
                busy    <= 1'b0;
                bit_cnt <= 4'd0;
            end else if (start_det) begin
                bit_cnt <= 4'd0;
            end else begin
                case (state)
                    S_ADDR, S_REG, S_WDATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= {shreg[6:0], sda_s2};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (state == S_ADDR && addr_match) busy <= 1'b1;
                            if (state == S_REG) reg_addr <= reg_mod;
                            if (state == S_WDATA) begin
                                reg_wr_en   <= 1'b1;
                                reg_wr_data <= shreg;
                            end
                        end
                    end
                    S_ACK_ADDR: begin
                        if (scl_fall && shreg[0]) begin
                            tx_byte <= reg_rd_data;
                            tx_cnt  <= 3'd0;
                        end
                    end
                    S_ACK_WDATA: begin
                        if (scl_fall) reg_addr <= addr_inc(reg_addr);
                    end
                    S_RDATA: begin
                        acked <= 1'b0;
                        if (scl_fall) begin
                            tx_byte <= {tx_byte[6:0], 1'b0};
                            tx_cnt  <= tx_cnt + 3'd1;
                        end
                    end
                    S_RACK: begin
                        if (scl_rise && !sda_s2) begin
                            acked    <= 1'b1;
                            reg_addr <= addr_inc(reg_addr);
                        end else if (scl_fall && acked) begin
                            tx_byte <= reg_rd_data;
                            tx_cnt  <= 3'd0;
                            acked   <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged I2C master drives SCL/SDA,
// a register array answers reads, and writes are logged for checking.
module tb_i2c_target;

    localparam int Q = 8;
    localparam logic [3:0] ST_IDLE = 4'd0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic       reg_wr_en;
    logic [7:0] reg_wr_data;
    logic [7:0] reg_rd_data;
    logic       busy;
    logic [3:0] fsm_state;

    logic [7:0]  mem [0:63];
    logic [15:0] wr_q [$];
    logic        oe_seen;
    logic        busy_seen;
    int          errors = 0;
    int          checks = 0;

    always #10 clk = ~clk;

    assign sda_line    = sda_m & ~sda_oe;
    assign reg_rd_data = mem[reg_addr[5:0]];

    i2c_target #(.DEV_ADDR(7'h1D), .NUM_REGS(64)) dut (
        .clk(clk), .rst(rst_n), .scl_i(scl_m), .sda_i(sda_line),
        .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wr_en(reg_wr_en),
        .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data),
        .busy(busy), .fsm_state(fsm_state)
    );

    // Write log and activity flags, sampled away from the active edge.
    always @(negedge clk) begin
        if (reg_wr_en) wr_q.push_back({reg_addr, reg_wr_data});
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic a1, a2;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        a1 = sda_oe; wait_q();
        a2 = sda_oe;
        scl_m = 1'b0; wait_q();
        ack = a1 & a2;
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        b = sda_line; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic recv_byte(input logic poke, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
            if (poke && i == 3) mem[reg_addr[5:0]] = 8'h00;
        end
    endtask

    // START from idle or repeated START from SCL low.
    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q(); wait_q();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe: got %b want 0", sda_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", reg_wr_en); end
        checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL rst_reg_addr: got %h want 00", reg_addr); end
        checks++; if (reg_wr_data !== 8'h00) begin errors++; $display("FAIL rst_wr_data: got %h want 00", reg_wr_data); end
        checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d want 0", fsm_state); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_write();
        logic a0, a1, a2;
        wr_q.delete();
        i2c_start();
        send_byte(8'h3A, a0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_hi: got %b want 1", busy); end
        send_byte(8'h2D, a1);
        send_byte(8'h08, a2);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL wr_acks: got %b want 111", {a0, a1, a2}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_lo: got %b want 0", busy); end
        checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL wr_count: got %0d want 1", wr_q.size()); end
        else begin
            checks++; if (wr_q[0] !== 16'h2D08) begin errors++; $display("FAIL wr_entry: got %h want 2d08", wr_q[0]); end
        end
        checks++; if (reg_addr !== 8'h2E) begin errors++; $display("FAIL wr_ptr_inc: got %h want 2e", reg_addr); end
    endtask

    task automatic test_read();
        logic a0, a1, a2;
        logic [7:0] d;
        wr_q.delete();
        mem[0] = 8'hE5;
        i2c_start();
        send_byte(8'h3A, a0);
        send_byte(8'h00, a1);
        i2c_start();
        send_byte(8'h3B, a2);
        recv_byte(1'b1, d);
        send_bit(1'b1);
        checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL rd_acks: got %b want 111", {a0, a1, a2}); end
        checks++; if (d !== 8'hE5) begin errors++; $display("FAIL rd_byte_latched: got %h want e5", d); end
        checks++; if (fsm_state !== ST_IDLE || sda_oe !== 1'b0) begin errors++; $display("FAIL rd_nack_idle: got state %0d oe %b want 0 0", fsm_state, sda_oe); end
        i2c_stop();
        checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL rd_no_write: got %0d want 0", wr_q.size()); end
        checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL rd_ptr_nack: got %h want 00", reg_addr); end
    endtask

    task automatic test_nomatch();
        logic a0, a1, a2;
        wr_q.delete();
        oe_seen = 1'b0; busy_seen = 1'b0;
        i2c_start();
        send_byte(8'hA6, a0);
        send_byte(8'h10, a1);
        send_byte(8'h55, a2);
        i2c_stop();
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL nm_sda_oe: got %b want 0", oe_seen); end
        checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL nm_busy: got %b want 0", busy_seen); end
        checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL nm_no_write: got %0d want 0", wr_q.size()); end
    endtask

    task automatic test_wrap();
        logic a;
        wr_q.delete();
        i2c_start();
        send_byte(8'h3A, a);
        send_byte(8'h3F, a);
        send_byte(8'hAA, a);
        send_byte(8'hBB, a);
        i2c_stop();
        checks++; if (wr_q.size() !== 2) begin errors++; $display("FAIL wrap_count: got %0d want 2", wr_q.size()); end
        else begin
            checks++; if (wr_q[0] !== 16'h3FAA) begin errors++; $display("FAIL wrap_first: got %h want 3faa", wr_q[0]); end
            checks++; if (wr_q[1] !== 16'h00BB) begin errors++; $display("FAIL wrap_second: got %h want 00bb", wr_q[1]); end
        end
    endtask

    task automatic test_modreg();
        logic a0, a1;
        wr_q.delete();
        i2c_start();
        send_byte(8'h3A, a0);
        send_byte(8'h45, a1);
        checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL mod_ack: got %b want 1", a1); end
        checks++; if (reg_addr !== 8'h05) begin errors++; $display("FAIL mod_ptr: got %h want 05", reg_addr); end
        send_byte(8'h11, a1);
        i2c_stop();
        checks++; if (wr_q.size() !== 1 || wr_q[0] !== 16'h0511) begin errors++; $display("FAIL mod_write: got n=%0d want one 0511", wr_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic a;
        logic [7:0] d0, d1;
        mem[63] = 8'h5A;
        mem[0]  = 8'hC3;
        i2c_start();
        send_byte(8'h3A, a);
        send_byte(8'h3F, a);
        i2c_start();
        send_byte(8'h3B, a);
        recv_byte(1'b0, d0);
        send_bit(1'b0);
        recv_byte(1'b0, d1);
        send_bit(1'b1);
        i2c_stop();
        checks++; if (d0 !== 8'h5A) begin errors++; $display("FAIL b2b_byte0: got %h want 5a", d0); end
        checks++; if (d1 !== 8'hC3) begin errors++; $display("FAIL b2b_byte1: got %h want c3", d1); end
        checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL b2b_ptr: got %h want 00", reg_addr); end
    endtask

    task automatic test_stop_mid();
        logic a;
        wr_q.delete();
        i2c_start();
        send_byte(8'h3A, a);
        send_byte(8'h20, a);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        i2c_stop();
        checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL stop_no_write: got %0d want 0", wr_q.size()); end
        checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL stop_state: got %0d want 0", fsm_state); end
        checks++; if (sda_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stop_release: got oe %b busy %b want 0 0", sda_oe, busy); end
        checks++; if (reg_addr !== 8'h20) begin errors++; $display("FAIL stop_ptr_kept: got %h want 20", reg_addr); end
    endtask

    task automatic test_reset_mid();
        logic a;
        logic b;
        mem[16] = 8'h00;
        i2c_start();
        send_byte(8'h3A, a);
        send_byte(8'h10, a);
        i2c_start();
        send_byte(8'h3B, a);
        recv_bit(b); recv_bit(b); recv_bit(b);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        checks++; if (sda_oe !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rm_pre: got oe %b busy %b want 1 1", sda_oe, busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (sda_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_async: got oe %b busy %b want 0 0", sda_oe, busy); end
        wait_q();
        scl_m = 1'b0; wait_q();
        rst_n = 1'b1;
        oe_seen = 1'b0; busy_seen = 1'b0;
        for (int i = 0; i < 12; i++) recv_bit(b);
        checks++; if (oe_seen !== 1'b0 || busy_seen !== 1'b0) begin errors++; $display("FAIL rm_silent: got oe %b busy %b want 0 0", oe_seen, busy_seen); end
        checks++; if (fsm_state !== ST_IDLE || reg_addr !== 8'h00) begin errors++; $display("FAIL rm_idle: got state %0d ptr %h want 0 00", fsm_state, reg_addr); end
        i2c_start();
        send_byte(8'h3A, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL rm_fresh_ack: got %b want 1", a); end
        i2c_stop();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_nomatch();
        test_wrap();
        test_modreg();
        test_back_to_back();
        test_stop_mid();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter: DEV_ADDR, default 7'h1D, 7-bit address the block answers to.
REQ-002 Parameter: NUM_REGS, default 64, depth of the register window; valid register addresses are 0..NUM_REGS-1.
REQ-003 Port: clk, input, 1, system clock (50 MHz nominal); the only clock.
REQ-004 Port: rst, input, 1, asynchronous active-low reset.
REQ-005 Port: scl_i, input, 1, raw SCL line level.
REQ-006 Port: sda_i, input, 1, raw SDA line level.
REQ-007 Port: sda_oe, output, 1, 1 = pull SDA low; 0 = release SDA (open-drain, pulled up externally).
REQ-008 Port: reg_addr, output, 8, current register pointer.
REQ-009 Port: reg_wr_en, output, 1, single-cycle write strobe.
REQ-010 Port: reg_wr_data, output, 8, byte written at reg_addr when reg_wr_en=1.
REQ-011 Port: reg_rd_data, input, 8, combinational read of register reg_addr.
REQ-012 Port: busy, output, 1, high from an address-matched START until the next STOP.

Function
REQ-013 The block SHALL pass scl_i and sda_i through 2-flop synchronizers before any use, and SHALL detect edges on the synchronized values.
REQ-014 START/repeated START SHALL be a synchronized SDA fall while SCL is high; STOP SHALL be a synchronized SDA rise while SCL is high; both SHALL be accepted in any state.
REQ-015 Input bits SHALL be sampled MSB-first on SCL rising edges; sda_oe SHALL change only on the clk cycle after a detected SCL falling edge, or on START/STOP.
REQ-016 FSM states: IDLE, ADDR, ACK_ADDR, REG, ACK_REG, WDATA, ACK_WDATA, RDATA, RACK.
REQ-017 IDLE -> ADDR on START; ADDR shifts 8 bits (7 address + R/W).
REQ-018 On the 8th-bit SCL fall in ADDR: match -> ACK_ADDR with sda_oe=1 and busy=1; mismatch -> IDLE with sda_oe=0 (ignore until next START).
REQ-019 ACK_ADDR exit on the next SCL fall: R/W=0 -> REG with sda_oe=0; R/W=1 -> RDATA with sda_oe = NOT reg_rd_data[7].
REQ-020 REG: after 8 bits, load reg_addr, drive ACK (ACK_REG, sda_oe=1), then WDATA on the next SCL fall.
REQ-021 WDATA: after 8 bits, assert reg_wr_en for exactly one clk with reg_wr_data = received byte, drive ACK (ACK_WDATA), then increment reg_addr and return to WDATA on the next SCL fall.
REQ-022 RDATA: shift out the latched byte MSB-first, one bit per SCL fall; release SDA on the fall after bit 0 and enter RACK.
REQ-023 RACK: sample SDA on the SCL rise; 0 (ACK) -> increment reg_addr and, on the next SCL fall, load reg_rd_data and drive its bit 7 in RDATA; 1 (NACK) -> IDLE-wait with SDA released until STOP or START.
REQ-024 reg_addr SHALL wrap from NUM_REGS-1 to 0 on increment; a REG byte >= NUM_REGS SHALL be ACKed and reduced modulo NUM_REGS.
REQ-025 Repeated START in any state SHALL release SDA and go to ADDR; reg_addr SHALL be kept, so that write-pointer-then-read works.
REQ-026 STOP in any state SHALL go to IDLE, release SDA and clear busy; reg_addr SHALL be kept.
REQ-027 The byte read (REQ-019/023) SHALL be latched at the load SCL fall; later changes on reg_rd_data SHALL not affect the byte in flight.

Reset
REQ-028 While rst=0: state=IDLE, sda_oe=0, busy=0, reg_wr_en=0, reg_addr=0, reg_wr_data=0, synchronizers=1 (idle bus).
REQ-029 Reset released mid-transfer SHALL leave the block in IDLE until a fresh START, even if SCL is toggling.

Verification
REQ-030 Write 0x1D+W, reg 0x2D, data 0x08, STOP -> three ACKs (sda_oe=1 through each 9th clock); one reg_wr_en pulse with reg_addr=0x2D, data=0x08; busy falls at STOP.
REQ-031 Write 0x1D+W, reg 0x00, repeated START, 0x1D+R with reg_rd_data=0xE5, master NACK, STOP -> SDA bits 1,1,1,0,0,1,0,1; no reg_wr_en.
REQ-032 Address 0x53+W -> sda_oe stays 0 for the whole transfer; busy stays 0; no reg_wr_en.
REQ-033 NUM_REGS=64, write reg 0x3F, data 0xAA, 0xBB -> writes at 0x3F then 0x00.
REQ-034 rst=0 asserted during bit 4 of RDATA -> sda_oe=0 and busy=0 immediately (asynchronous); after release, no response until the next START.
REQ-035 STOP injected after bit 3 of WDATA -> IDLE, no reg_wr_en, SDA released.
